// File: rtl/vga_plot_scheduler_pkg.sv
// rtl/vga_plot_scheduler_pkg.sv - shared types and screen defaults for the VGA plot scheduler
// Contents: color_t (one 5-bit field per RGB channel), sched_state_t (ARB/CLEAR),
// and the default screen geometry used by the scheduler and its interface.
package vga_pkg;

  localparam int PKG_BITS_PER_CHANNEL = 5;
  localparam int DEFAULT_WIDTH        = 1680 / 5;
  localparam int DEFAULT_HEIGHT       = 1050 / 5;

  typedef logic [2:0][PKG_BITS_PER_CHANNEL-1:0] color_t;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } sched_state_t;

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// rtl/vga_plot_scheduler_if.sv - request, clear-control and adapter-side signals of the plot scheduler
// Signals:
//   req_valid/req_ready    per-client pixel handshake, transfer when both high
//   req_x/req_y/req_color  per-client pixel coordinates and colour
//   clear_start/clear_color/clear_busy  full-screen clear control and status
//   x/y/color/plot         registered pixel write towards the VGA adapter
// Modports: master = drawing clients side, slave = scheduler side.
interface vga_plot_scheduler_if import vga_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int WIDTH2  = $clog2(DEFAULT_WIDTH),
  parameter int HEIGHT2 = $clog2(DEFAULT_HEIGHT),
  parameter int COLOR_W = 3 * PKG_BITS_PER_CHANNEL
);

  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ-1:0]               req_ready;
  logic [N_REQ-1:0][WIDTH2-1:0]   req_x;
  logic [N_REQ-1:0][HEIGHT2-1:0]  req_y;
  logic [N_REQ-1:0][COLOR_W-1:0]  req_color;

  logic                           clear_start;
  logic [COLOR_W-1:0]             clear_color;
  logic                           clear_busy;

  logic [WIDTH2-1:0]              x;
  logic [HEIGHT2-1:0]             y;
  logic [COLOR_W-1:0]             color;
  logic                           plot;

  modport master (
    output req_valid, req_x, req_y, req_color, clear_start, clear_color,
    input  req_ready, clear_busy, x, y, color, plot
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color, clear_start, clear_color,
    output req_ready, clear_busy, x, y, color, plot
  );

endinterface

// File: rtl/vga_plot_scheduler_rr_arbiter.sv
// rtl/vga_plot_scheduler_rr_arbiter.sv - round-robin arbiter with a registered rotation pointer
// Ports:
//   clk50  in   clock
//   reset  in   synchronous active-high reset, clears the pointer
//   req    in   N request lines
//   en     in   arbitration enable; no grant and no pointer movement when low
//   grant  out  one-hot grant, combinational from req, en and the pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk50,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] cand;
  logic          found;

  // Walk the candidates starting at rr_ptr, wrapping at N-1 explicitly so a
  // non-power-of-two N never visits indices beyond the last requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = rr_ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && en && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vga_plot_scheduler.sv
// rtl/vga_plot_scheduler.sv - round-robin share of the VGA pixel-write port plus full-screen clear
// Ports:
//   clk50  in   board clock, all logic on its rising edge
//   reset  in   synchronous active-high reset
//   bus    slave modport of vga_plot_scheduler_if:
//            req_* in / req_ready out  client pixel handshake
//            clear_start/clear_color in, clear_busy out
//            x/y/color/plot out        registered adapter write, one pixel per cycle max
module vga_plot_scheduler import vga_pkg::*; #(
  parameter int N_REQ            = 4,
  parameter int BITS_PER_CHANNEL = PKG_BITS_PER_CHANNEL,
  parameter int WIDTH            = DEFAULT_WIDTH,
  parameter int HEIGHT           = DEFAULT_HEIGHT,
  parameter int WIDTH2           = $clog2(WIDTH),
  parameter int HEIGHT2          = $clog2(HEIGHT)
) (
  input  logic                 clk50,
  input  logic                 reset,
  vga_plot_scheduler_if.slave  bus
);

  localparam int CW = 3 * BITS_PER_CHANNEL;
  localparam logic [WIDTH2-1:0]  X_LAST = WIDTH2'(WIDTH - 1);
  localparam logic [HEIGHT2-1:0] Y_LAST = HEIGHT2'(HEIGHT - 1);

  sched_state_t       state;
  logic               busy_q;
  logic [WIDTH2-1:0]  sweep_x;
  logic [HEIGHT2-1:0] sweep_y;
  logic [CW-1:0]      clear_col;

  logic [WIDTH2-1:0]  x_q;
  logic [HEIGHT2-1:0] y_q;
  logic [CW-1:0]      color_q;
  logic               plot_q;

  logic               arb_en;
  logic [N_REQ-1:0]   grant;
  logic               g_any;
  logic               g_in_range;
  logic [WIDTH2-1:0]  gx;
  logic [HEIGHT2-1:0] gy;
  logic [CW-1:0]      gc;

  // A pending clear_start wins the cycle outright; reset also suppresses
  // grants so req_ready reads zero while reset is held.
  assign arb_en = !reset && (state == ARB) && !bus.clear_start;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk50 (clk50),
    .reset (reset),
    .req   (bus.req_valid),
    .en    (arb_en),
    .grant (grant)
  );

  assign bus.req_ready = grant;

  // One-hot grant, so OR-ing the masked client fields selects the winner.
  always_comb begin
    gx = '0;
    gy = '0;
    gc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gx = gx | bus.req_x[i];
        gy = gy | bus.req_y[i];
        gc = gc | bus.req_color[i];
      end
    end
    g_any      = |grant;
    g_in_range = (gx <= X_LAST) && (gy <= Y_LAST);
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state     <= ARB;
      busy_q    <= 1'b0;
      sweep_x   <= '0;
      sweep_y   <= '0;
      clear_col <= '0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
      plot_q    <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (bus.clear_start) begin
            clear_col <= bus.clear_color;
            sweep_x   <= '0;
            sweep_y   <= '0;
            state     <= CLEAR;
            busy_q    <= 1'b1;
            plot_q    <= 1'b0;
          end else if (g_any && g_in_range) begin
            x_q     <= gx;
            y_q     <= gy;
            color_q <= gc;
            plot_q  <= 1'b1;
          end else begin
            // Off-screen pixels are consumed but never reach the adapter;
            // x/y/color keep their previous values.
            plot_q <= 1'b0;
          end
        end

        CLEAR: begin
          x_q     <= sweep_x;
          y_q     <= sweep_y;
          color_q <= clear_col;
          plot_q  <= 1'b1;
          if (sweep_x == X_LAST) begin
            sweep_x <= '0;
            if (sweep_y == Y_LAST) begin
              // This cycle issues the bottom-right pixel; arbitration resumes next.
              state  <= ARB;
              busy_q <= 1'b0;
            end else begin
              sweep_y <= sweep_y + 1'b1;
            end
          end else begin
            sweep_x <= sweep_x + 1'b1;
          end
        end

        default: begin
          state  <= ARB;
          busy_q <= 1'b0;
          plot_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.color      = color_q;
  assign bus.plot       = plot_q;
  assign bus.clear_busy = busy_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// tb/tb_vga_plot_scheduler.sv - self-checking bench for vga_plot_scheduler
module tb_vga_plot_scheduler;
  import vga_pkg::*;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 336;
  localparam int HEIGHT   = 210;
  localparam int W2       = 9;
  localparam int H2       = 8;
  localparam int CW       = 15;
  localparam int N_PIXELS = WIDTH * HEIGHT;
  localparam int NV       = 20;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  always #5 clk50 = ~clk50;

  vga_plot_scheduler_if #(.N_REQ(N_REQ), .WIDTH2(W2), .HEIGHT2(H2), .COLOR_W(CW)) bus();

  vga_plot_scheduler #(
    .N_REQ(N_REQ), .BITS_PER_CHANNEL(5), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .WIDTH2(W2), .HEIGHT2(H2)
  ) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W2-1:0] x;
    logic [H2-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  typedef struct {
    logic [3:0] valid;
    int         oc;    // overridden client, -1 for none
    int         ox;
    int         oy;
    int         ocol;
    logic [3:0] exp_grant;
  } vec_t;

  pix_t sb[$];
  pix_t mon_exp;
  vec_t vt[NV];
  int   n_vec = 0;
  int   n_err = 0;
  int   plot_count = 0;
  int   cx[N_REQ];
  int   cy[N_REQ];
  int   ccol[N_REQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input int oc, input int ox,
                              input int oy, input int ocol, input logic [3:0] eg);
    vec_t v;
    v.valid = valid; v.oc = oc; v.ox = ox; v.oy = oy; v.ocol = ocol; v.exp_grant = eg;
    return v;
  endfunction

  function automatic pix_t mkpix(input int px, input int py, input int pc);
    pix_t p;
    p.x = W2'(px); p.y = H2'(py); p.c = CW'(pc);
    return p;
  endfunction

  task automatic drive_clients();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_x[i]     = W2'(cx[i]);
      bus.req_y[i]     = H2'(cy[i]);
      bus.req_color[i] = CW'(ccol[i]);
    end
  endtask

  // Scoreboard consumer: every plot pulse must match the oldest expected pixel.
  always @(negedge clk50) begin
    if (bus.plot === 1'b1) begin
      plot_count++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_plot: plot=1 at (%0d,%0d) color 0x%0h, expected no plot",
                 bus.x, bus.y, bus.color);
      end else begin
        mon_exp = sb.pop_front();
        check("plot_pixel", 64'({bus.x, bus.y, bus.color}), 64'(mon_exp));
      end
    end
  end

  initial begin : main
    logic prev_plot;
    color_t cc;
    int busy_cycles;
    int ready_bad;
    int snap;
    int k;
    bit done;

    // Grant sequence with the pointer evolving from 0; expected grants worked by hand.
    vt[0]  = mk(4'b1111, -1, 0, 0, 0, 4'b0001);
    vt[1]  = mk(4'b1111, -1, 0, 0, 0, 4'b0010);
    vt[2]  = mk(4'b1111, -1, 0, 0, 0, 4'b0100);
    vt[3]  = mk(4'b1111, -1, 0, 0, 0, 4'b1000);
    vt[4]  = mk(4'b1111, -1, 0, 0, 0, 4'b0001);
    vt[5]  = mk(4'b1111, -1, 0, 0, 0, 4'b0010);
    vt[6]  = mk(4'b1111, -1, 0, 0, 0, 4'b0100);
    vt[7]  = mk(4'b1111, -1, 0, 0, 0, 4'b1000);
    vt[8]  = mk(4'b0000, -1, 0, 0, 0, 4'b0000);
    vt[9]  = mk(4'b0100,  2, 10, 20, 'h7FFF, 4'b0100);
    vt[10] = mk(4'b0100,  2, 11, 20, 'h7FFF, 4'b0100);
    vt[11] = mk(4'b1001, -1, 0, 0, 0, 4'b1000);
    vt[12] = mk(4'b0010,  1, 336, 5, 'h1111, 4'b0010);
    vt[13] = mk(4'b0111, -1, 0, 0, 0, 4'b0100);
    vt[14] = mk(4'b0011, -1, 0, 0, 0, 4'b0001);
    vt[15] = mk(4'b0001,  0, 335, 209, 'h5555, 4'b0001);
    vt[16] = mk(4'b0010,  1, 0, 210, 'h0001, 4'b0010);
    vt[17] = mk(4'b1111, -1, 0, 0, 0, 4'b0100);
    vt[18] = mk(4'b1000, -1, 0, 0, 0, 4'b1000);
    vt[19] = mk(4'b0000, -1, 0, 0, 0, 4'b0000);

    // Reset state, with every client requesting to show ready stays low.
    bus.req_valid   = 4'b1111;
    bus.clear_start = 1'b0;
    bus.clear_color = '0;
    for (int i = 0; i < N_REQ; i++) begin cx[i] = i; cy[i] = i; ccol[i] = i; end
    drive_clients();
    reset = 1'b1;
    repeat (2) @(posedge clk50);
    #1;
    @(negedge clk50);
    check("rst_plot",  64'(bus.plot), 64'(0));
    check("rst_x",     64'(bus.x), 64'(0));
    check("rst_y",     64'(bus.y), 64'(0));
    check("rst_color", 64'(bus.color), 64'(0));
    check("rst_busy",  64'(bus.clear_busy), 64'(0));
    check("rst_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk50);
    #1;
    reset = 1'b0;

    // Table-driven arbitration vectors.
    prev_plot = 1'b0;
    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < N_REQ; i++) begin
        cx[i] = v * 4 + i; cy[i] = i + 1; ccol[i] = v * 256 + i * 16 + 3;
      end
      if (vt[v].oc >= 0) begin
        cx[vt[v].oc] = vt[v].ox; cy[vt[v].oc] = vt[v].oy; ccol[vt[v].oc] = vt[v].ocol;
      end
      drive_clients();
      bus.req_valid = vt[v].valid;
      @(negedge clk50);
      check($sformatf("ready_v%0d", v), 64'(bus.req_ready), 64'(vt[v].exp_grant));
      check($sformatf("plot_v%0d", v), 64'(bus.plot), 64'(prev_plot));
      prev_plot = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        if (vt[v].exp_grant[i] && cx[i] < WIDTH && cy[i] < HEIGHT) begin
          sb.push_back(mkpix(cx[i], cy[i], ccol[i]));
          prev_plot = 1'b1;
        end
      end
      @(posedge clk50);
      #1;
    end
    @(negedge clk50);
    check("plot_after_table", 64'(bus.plot), 64'(prev_plot));
    @(posedge clk50);
    #1;

    // Full clear with clients 0 and 3 waiting; a second clear_start mid-sweep is ignored.
    cx[0] = 7; cy[0] = 8; ccol[0] = 'h1234;
    cx[3] = 9; cy[3] = 4; ccol[3] = 'h4321;
    drive_clients();
    bus.req_valid   = 4'b1001;
    cc              = 15'h001F;
    bus.clear_color = cc;
    bus.clear_start = 1'b1;
    @(negedge clk50);
    check("ready_on_clear_start", 64'(bus.req_ready), 64'(0));
    check("busy_on_clear_start", 64'(bus.clear_busy), 64'(0));
    for (int p = 0; p < N_PIXELS; p++) sb.push_back(mkpix(p % WIDTH, p / WIDTH, int'(cc)));
    @(posedge clk50);
    #1;
    bus.clear_start = 1'b0;
    bus.clear_color = 15'h7C00;
    snap = plot_count;
    busy_cycles = 0;
    ready_bad = 0;
    k = 0;
    done = 1'b0;
    @(negedge clk50);
    while (!done && k < N_PIXELS + 20) begin
      if (bus.clear_busy === 1'b1) begin
        busy_cycles++;
        if (bus.req_ready !== 4'b0000) ready_bad++;
      end else begin
        done = 1'b1;
      end
      bus.clear_start = (k == 100);
      if (!done) begin
        @(negedge clk50);
        k++;
      end
    end
    bus.clear_start = 1'b0;
    check("clear_completed", 64'(done), 64'(1));
    check("clear_busy_cycles", 64'(busy_cycles), 64'(N_PIXELS));
    check("ready_during_clear", 64'(ready_bad), 64'(0));
    check("ready_after_clear", 64'(bus.req_ready), 64'(4'b0001));
    check("plot_last_sweep", 64'(bus.plot), 64'(1));
    sb.push_back(mkpix(cx[0], cy[0], ccol[0]));
    @(posedge clk50);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk50);
    check("plot_client0_after_clear", 64'(bus.plot), 64'(1));
    @(negedge clk50);
    check("plot_idle_after_clear", 64'(bus.plot), 64'(0));
    check("clear_plot_count", 64'(plot_count - snap), 64'(N_PIXELS + 1));
    check("sb_empty_after_clear", 64'(sb.size()), 64'(0));

    // Reset in the middle of a sweep: pixels 0..499 appear, then nothing.
    @(posedge clk50);
    #1;
    bus.clear_color = 15'h03E0;
    bus.clear_start = 1'b1;
    for (int p = 0; p < 500; p++) sb.push_back(mkpix(p % WIDTH, p / WIDTH, 'h03E0));
    @(posedge clk50);
    #1;
    bus.clear_start = 1'b0;
    snap = plot_count;
    repeat (500) @(posedge clk50);
    #1;
    reset = 1'b1;
    bus.req_valid = 4'b1001;
    @(posedge clk50);
    #1;
    @(negedge clk50);
    check("midclr_rst_plot", 64'(bus.plot), 64'(0));
    check("midclr_rst_busy", 64'(bus.clear_busy), 64'(0));
    check("midclr_rst_ready", 64'(bus.req_ready), 64'(0));
    check("midclr_plot_count", 64'(plot_count - snap), 64'(500));
    check("midclr_sb_empty", 64'(sb.size()), 64'(0));
    @(posedge clk50);
    #1;
    reset = 1'b0;
    bus.req_valid = 4'b0000;
    snap = plot_count;
    repeat (6) @(posedge clk50);
    #1;
    check("no_plots_after_reset", 64'(plot_count - snap), 64'(0));
    // Pointer was 1 before reset; with 0 and 3 valid only a cleared pointer picks 0.
    bus.req_valid = 4'b1001;
    @(negedge clk50);
    check("ptr_after_reset", 64'(bus.req_ready), 64'(4'b0001));
    sb.push_back(mkpix(cx[0], cy[0], ccol[0]));
    @(posedge clk50);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk50);
    check("plot_after_reset_grant", 64'(bus.plot), 64'(1));
    repeat (3) @(negedge clk50);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_plot_scheduler.md
# vga_plot_scheduler

Shares the single pixel-write port of the VGA adapter among `N_REQ` independent drawing clients, and adds a built-in full-screen clear sequencer. Sits between the drawing engines and the adapter's `x`/`y`/`color`/`plot` inputs, in the `clk50` domain. Grants are round-robin and at most one pixel is issued per cycle. The adapter has no back-pressure, so the output never stalls.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `BITS_PER_CHANNEL`, 5, bits per colour channel
- `WIDTH`, 336, screen width in pixels
- `HEIGHT`, 210, screen height in pixels
- `WIDTH2`, $clog2(WIDTH), x width
- `HEIGHT2`, $clog2(HEIGHT), y width

Ports:
- `clk50`  in  1  board clock; one clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  N_REQ  per-client pixel request
- `req_ready`  out  N_REQ  per-client accept; transfer when valid&ready
- `req_x`  in  N_REQ×WIDTH2  per-client x
- `req_y`  in  N_REQ×HEIGHT2  per-client y
- `req_color`  in  N_REQ×3×BITS_PER_CHANNEL  per-client colour
- `clear_start`  in  1  start full-screen clear (sampled each cycle)
- `clear_color`  in  3×BITS_PER_CHANNEL  fill colour, latched on `clear_start` acceptance
- `clear_busy`  out  1  clear sweep in progress
- `x`  out  WIDTH2  to adapter
- `y`  out  HEIGHT2  to adapter
- `color`  out  3×BITS_PER_CHANNEL  to adapter
- `plot`  out  1  to adapter; one pulse per written pixel

## Operation
- States: `ARB`, `CLEAR`. Reset enters `ARB`.
- `ARB`, `clear_start`=0:
  - Grant the first valid requester at or after `rr_ptr`, searching upward modulo `N_REQ`.
  - `req_ready` is one-hot on the grant and combinational from `req_valid`, `rr_ptr` and state. It is all-zero if no requester is valid.
  - On grant g, `rr_ptr` ← (g+1) mod `N_REQ`. If there is no grant, `rr_ptr` holds.
- `ARB`, `clear_start`=1:
  - No grant that cycle; all `req_ready`=0.
  - Latch `clear_color`, zero the sweep counters and go to `CLEAR`.
  - Clear has priority over simultaneous requests.
- `CLEAR`:
  - All `req_ready`=0 and `clear_busy`=1.
  - One pixel per cycle, row-major: x counts 0..WIDTH-1; on wrap, x←0 and y increments; y runs 0..HEIGHT-1.
  - The cycle that issues (WIDTH-1, HEIGHT-1) is the last `CLEAR` cycle; the FSM then returns to `ARB`.
  - `clear_start` is ignored while in `CLEAR`.
- Accepted requester pixel with `req_x`≥WIDTH or `req_y`≥HEIGHT: consumed (ready asserted) but dropped; `plot` stays 0 next cycle. The round-robin pointer still advances.
- Outputs `x`/`y`/`color`/`plot` are registered. When `plot`=0, `x`/`y`/`color` hold their last values.
- Reset mid-clear: sweep aborted, no further plots.

## Timing
- Reset values: `plot`=0, `x`=0, `y`=0, `color`=0, `clear_busy`=0, `req_ready`=0, `rr_ptr`=0, state `ARB`.
- Request accepted at edge t → `plot`=1 with that pixel during cycle t+1. Latency 1.
- Back-to-back grants give one plot per cycle, with no bubbles.
- `clear_start` sampled at t:
  - `clear_busy`=1 for cycles t+1 … t+N_PIXELS, where N_PIXELS = WIDTH×HEIGHT.
  - Plots are visible t+2 … t+N_PIXELS+1, first (0,0), last (WIDTH-1,HEIGHT-1).
  - Requests can be accepted again from cycle t+N_PIXELS+1.
- Sweep counter arithmetic is exact-width, with compare-to-limit wrap (no power-of-two wrap).

## Structure
- Package `vga_pkg`:
  - `color_t` (logic [2:0][BITS_PER_CHANNEL-1:0], parameterised via package localparam matching the adapter default 5)
  - `sched_state_t` enum {`ARB`, `CLEAR`}
  - default `WIDTH`/`HEIGHT` localparams (1680/5, 1050/5)
- Sub-module `rr_arbiter` (param `N`): inputs `clk50`, `reset`, `req`, `en`; outputs one-hot `grant`. Owns `rr_ptr`, which advances only on a grant while `en`=1.
- Top instantiates `rr_arbiter`, the FSM, the sweep counters and the output register.

## Test plan
- Reset, then all `req_valid`=1 held for 8 cycles (N_REQ=4) → grants 0,1,2,3,0,1,2,3. `plot` is high on cycles 2–9 after the first grant cycle, with the matching x/y/color.
- Only client 2 valid with (10,20,colour 0x7FFF), then (11,20) → two consecutive plots, each 1 cycle after acceptance. `rr_ptr` is 3 after each.
- Client 1 valid with x=336, y=5 → `req_ready[1]`=1 for one cycle, `plot` stays 0, and the next grant goes to client 2 if it is valid.
- `clear_start` with clear_color=0x001F while clients 0 and 3 are valid → no grant that cycle. Then 70560 plots in row-major order (0,0)…(335,209), all colour 0x001F, and `clear_busy` is high for exactly 70560 cycles. Client 0 is granted on the cycle after the last `clear_busy`.
- `clear_start` pulsed again at sweep pixel 100 → ignored; the sweep completes normally with 70560 plots.
- `reset` asserted at sweep pixel 500 → next cycle `plot`=0, `clear_busy`=0, state `ARB`, `rr_ptr`=0. No further plots without a new request.
